// File: rtl/aes_spi_frame_slave.sv
// SPI-slave (mode 0) framing front end for the AES core: receives text, key size and
// key, hands them to the core with a start/done handshake, then returns the result on miso.
module aes_spi_frame_slave #(
  parameter int SYNC_STAGES   = 2,
  parameter int TEXT_BYTES    = 16,
  parameter int MAX_KEY_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cs,
  input  logic                         sclk,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         done,
  output logic                         busy,
  output logic                         frame_error,
  output logic [8*TEXT_BYTES-1:0]      block_out,
  output logic [8*MAX_KEY_BYTES-1:0]   key_out,
  output logic [7:0]                   key_size_out,
  output logic                         core_start,
  input  logic                         core_done,
  input  logic [8*TEXT_BYTES-1:0]      core_result
);

  localparam int TEXT_W = 8 * TEXT_BYTES;
  localparam int KEY_W  = 8 * MAX_KEY_BYTES;

  typedef enum logic [2:0] {
    IDLE, RX_TEXT, RX_SIZE, RX_KEY, WAIT_CORE, TX_RESULT, DISCARD
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          rx_shift_q, rx_shift_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic [TEXT_W-9:0]   tx_hold_q, tx_hold_d;
  logic [7:0]          byte_idx_q, byte_idx_d;
  logic [TEXT_W-1:0]   block_q, block_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [7:0]          key_size_q, key_size_d;
  logic                done_q, done_d;
  logic                frame_error_q, frame_error_d;
  logic                core_start_q, core_start_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic engine_en, byte_done;
  logic [7:0] rx_byte;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign rx_byte   = {rx_shift_q, mosi_s};

  // The bit engine only runs inside a frame, so a master clocking while we sit in
  // IDLE (e.g. just after a reset) produces no done pulses.
  assign engine_en = ~cs_s && (state_q != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    byte_idx_d    = byte_idx_q;
    block_d       = block_q;
    key_d         = key_q;
    key_size_d    = key_size_q;
    frame_error_d = 1'b0;
    core_start_d  = 1'b0;
    byte_done     = 1'b0;

    if (!engine_en) begin
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      rx_shift_d = rx_byte[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_done  = (bit_cnt_q == 3'd7);
    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
      // The fall right after a byte boundary must not shift: the freshly loaded MSB
      // has to stay on miso until the next rise.
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
    done_d = byte_done;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = RX_TEXT;
          byte_idx_d = 8'd0;
          key_d      = '0;
        end
      end
      RX_TEXT: begin
        if (cs_rise) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (byte_done) begin
          for (int i = 0; i < TEXT_BYTES; i++)
            if (byte_idx_q == 8'(i)) block_d[TEXT_W-1-8*i -: 8] = rx_byte;
          if (byte_idx_q == 8'(TEXT_BYTES - 1)) begin
            state_d    = RX_SIZE;
            byte_idx_d = 8'd0;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      RX_SIZE: begin
        if (cs_rise) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (byte_done) begin
          if (rx_byte == 8'd16 || rx_byte == 8'd24 || rx_byte == 8'd32) begin
            key_size_d = rx_byte;
            byte_idx_d = 8'd0;
            state_d    = RX_KEY;
          end else begin
            frame_error_d = 1'b1;
            state_d       = DISCARD;
          end
        end
      end
      RX_KEY: begin
        if (cs_rise) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (byte_done) begin
          for (int i = 0; i < MAX_KEY_BYTES; i++)
            if (byte_idx_q == 8'(i)) key_d[KEY_W-1-8*i -: 8] = rx_byte;
          if (byte_idx_q == key_size_q - 8'd1) begin
            core_start_d = 1'b1;
            state_d      = WAIT_CORE;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      WAIT_CORE: begin
        // cs may rise here; the result waits for the next cs-low window.
        if (core_done) begin
          tx_shift_d = core_result[TEXT_W-1 -: 8];
          tx_hold_d  = core_result[TEXT_W-9:0];
          byte_idx_d = 8'd0;
          state_d    = TX_RESULT;
        end
      end
      TX_RESULT: begin
        if (cs_rise) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (byte_done) begin
          if (byte_idx_q == 8'(TEXT_BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
            tx_shift_d = tx_hold_q[TEXT_W-9 -: 8];
            tx_hold_d  = {tx_hold_q[TEXT_W-17:0], 8'h00};
          end
        end
      end
      DISCARD: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_hold_q     <= '0;
      byte_idx_q    <= '0;
      block_q       <= '0;
      key_q         <= '0;
      key_size_q    <= '0;
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
      core_start_q  <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      byte_idx_q    <= byte_idx_d;
      block_q       <= block_d;
      key_q         <= key_d;
      key_size_q    <= key_size_d;
      done_q        <= done_d;
      frame_error_q <= frame_error_d;
      core_start_q  <= core_start_d;
    end
  end

  assign miso         = (state_q == TX_RESULT) & tx_shift_q[7];
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign frame_error  = frame_error_q;
  assign core_start   = core_start_q;
  assign block_out    = block_q;
  assign key_out      = key_q;
  assign key_size_out = key_size_q;

endmodule

// File: doc/aes_spi_frame_slave.md
Name: aes_spi_frame_slave

Overview:
- SPI-slave framing front end for the AES core, used by both the encrypt and decrypt datapaths.
- It is the responder to the host SPI master. It receives the frame: 16 text bytes, 1 key-size byte, then key-size key bytes.
- It presents the block, key and key size to the core with a start/done handshake, then shifts the 16-byte result back out on miso.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on sclk/cs/mosi into the clk domain.
- TEXT_BYTES, 16, text/result length in bytes.
- MAX_KEY_BYTES, 32, width of the key register in bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  SPI chip select, active low
- sclk  in  1  SPI clock, mode 0
- mosi  in  1  SPI data from master, MSB first
- miso  out  1  SPI data to master, MSB first
- done  out  1  one-clk pulse per completed SPI byte
- busy  out  1  high whenever state != IDLE
- frame_error  out  1  one-clk pulse on a bad key size or an aborted frame
- block_out  out  128  received text, first byte in [127:120]
- key_out  out  256  received key, left-aligned, unused low bytes zero
- key_size_out  out  8  received key size: 16, 24 or 32
- core_start  out  1  one-clk pulse; block/key/size are valid
- core_done  in  1  one-clk pulse from the core; result is valid
- core_result  in  128  core output

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state advances on posedge clk only.
- Input sampling: sclk, cs and mosi pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk. The master must keep sclk high and low each >= 4 clk.
- Reset values: all outputs 0; miso=0; busy=0; block_out/key_out/key_size_out=0; state=IDLE; bit counter=0.
- Bit/byte engine:
  - Active only while synced cs=0.
  - Shift mosi in on each sclk rise. On the 8th rise, pulse done for 1 clk with the byte available internally.
  - miso is driven from tx_shift[7]; tx_shift moves left on each sclk fall. The next tx byte is loaded at the byte boundary so its MSB is on miso before the first rise.
  - When cs goes high, the bit counter clears; a partial byte is discarded.
- States:
  - IDLE: on cs falling go to RX_TEXT; byte index=0; key_out is cleared.
  - RX_TEXT: byte k lands in block_out[127-8k -: 8]. After byte 15 go to RX_SIZE.
  - RX_SIZE: byte in {16,24,32} latches key_size_out and goes to RX_KEY. Any other value pulses frame_error and goes to DISCARD.
  - RX_KEY: byte k lands in key_out[255-8k -: 8]. After key_size_out bytes, pulse core_start the next clk and go to WAIT_CORE.
  - WAIT_CORE: bytes clocked by the master are ignored and miso=0. On core_done, latch core_result into tx holding, load byte 0 and go to TX_RESULT.
  - TX_RESULT: bytes 0..15 are shifted out MSB first and mosi is ignored. After the 16th done, go to IDLE.
  - DISCARD: ignore everything, miso=0, until cs rises, then go to IDLE.
- Abort: cs rising in RX_TEXT, RX_SIZE, RX_KEY or TX_RESULT pulses frame_error and goes to IDLE. cs rising in WAIT_CORE is legal; the state is kept and the result is sent on the next cs-low window.
- A core_done outside WAIT_CORE is ignored.
- Reset takes priority over every event, including mid-byte and mid-TX: everything returns to reset values in the same clk.
- block_out, key_out and key_size_out hold their values from core_start until the next frame begins.

Test Plan:
- 128-bit frame:
  - Stimulus: text 00112233445566778899aabbccddeeff, size 16, key 000102030405060708090a0b0c0d0e0f; the core model returns 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: exactly one core_start; key_out = key followed by 128 zero bits; miso bytes 69,c4,...,5a in order; 33 data-in done pulses + 16 result done pulses.
- 192-bit frame:
  - Stimulus: same text, size 24, key 000102...1617; core model returns dda97ca4864cdfe06eaf70a0ec0d7191.
  - Response: key_out[63:0]=0; the result is read back bit-exact.
- 256-bit frame:
  - Stimulus: key 000102...1e1f; core model returns 8ea2b7ca516745bfeafc49904b496089.
  - Response: core_start after the 49th byte; the result matches.
- Bad size:
  - Stimulus: size byte 8'd20.
  - Response: one frame_error pulse; no core_start; miso=0 until cs rises; busy falls when cs rises.
- Abort:
  - Stimulus: cs raised after 5 key bytes.
  - Response: frame_error pulse; state IDLE; a following valid frame completes normally.
- Reset mid-TX:
  - Stimulus: reset asserted after result byte 7.
  - Response: all outputs 0 at the next posedge; no further done pulses.
